spi_exch_word: RTL and testbench

- Parametrised successor to the fixed 8-bit SPI exchange engine.
- Generates its own SCLK from clk_i through a programmable divider and supports all four CPOL/CPHA modes.
- Exchange length is selectable per transfer (1..DATA_W bits), with MSB- or LSB-first ordering.
- Sits between the AXI-lite register file and the SPI pads; chip-select is owned by the register file.

---
 rtl/spi_exch_word.sv | 164 ++++++++++++++++
 tb/tb_spi_exch_word.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/spi_exch_word.sv
// spi_exch_word: SPI master exchange engine, 1..DATA_W bits per transfer.
// SCLK is divided down from clk_i. All four CPOL/CPHA modes are supported, with MSB- or LSB-first order.
// Chip-select is not handled here; the register file drives it.
//
// Ports:
//   clk_i        system clock
//   rst_i        synchronous active-high reset
//   start_i      transfer request, sampled only in IDLE
//   cpol_i       SCLK idle level
//   cpha_i       0 = sample on leading edge, 1 = sample on trailing edge
//   lsb_first_i  1 = LSB first, 0 = MSB first
//   div_i        SCLK half-period minus one, in clk_i cycles
//   len_i        bits per word minus one
//   data_i       TX word, right-justified
//   miso_i       serial input
//   busy_o       transfer in progress
//   done_o       one-cycle completion pulse
//   data_o       RX word, right-justified, zero-extended
//   sclk_o       serial clock
//   mosi_o       serial output
module spi_exch_word #(
  parameter int DATA_W = 16,
  parameter int DIV_W  = 8,
  parameter int LEN_W  = $clog2(DATA_W)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              cpol_i,
  input  logic              cpha_i,
  input  logic              lsb_first_i,
  input  logic [DIV_W-1:0]  div_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              miso_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] data_o,
  output logic              sclk_o,
  output logic              mosi_o
);

  // The edge counter must reach 2*DATA_W without wrapping. DATA_W <= 2**LEN_W, so 2 extra bits are enough.
  localparam int EC_W = LEN_W + 2;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state;
  logic              cpol_q, cpha_q, lsb_q;
  logic [DIV_W-1:0]  div_q;
  logic [LEN_W-1:0]  len_q;
  logic [DATA_W-1:0] tx_sr, rx_sr;
  logic [DIV_W-1:0]  hp_cnt;
  logic [EC_W-1:0]   edge_cnt;

  // Keeps bits 0..len and clears the bits above len.
  function automatic logic [DATA_W-1:0] len_mask(input logic [LEN_W-1:0] len);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < DATA_W; i++)
      m[i] = (LEN_W'(i) <= len);
    return m;
  endfunction

  // Reverses bits 0..len and zeroes the bits above len.
  function automatic logic [DATA_W-1:0] rev_len(input logic [DATA_W-1:0] d,
                                                input logic [LEN_W-1:0]  len);
    logic [DATA_W-1:0] r;
    logic [LEN_W-1:0]  idx;
    r = '0;
    for (int i = 0; i < DATA_W; i++) begin
      idx = len - LEN_W'(i);
      if (LEN_W'(i) <= len) r[i] = d[idx];
    end
    return r;
  endfunction

  // The TX register always shifts out from bit 0. For MSB-first, the word is mirrored at load time.
  logic [DATA_W-1:0] tx_load;
  assign tx_load = lsb_first_i ? (data_i & len_mask(len_i)) : rev_len(data_i, len_i);

  // Odd edges (edge_cnt even before the increment) are leading edges.
  logic lead, sample, last;
  assign lead   = ~edge_cnt[0];
  assign sample = lead ^ cpha_q;
  assign last   = (edge_cnt == {1'b0, len_q, 1'b1});   // edge 2N is about to fire

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      data_o   <= '0;
      sclk_o   <= 1'b0;
      mosi_o   <= 1'b1;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      lsb_q    <= 1'b0;
      div_q    <= '0;
      len_q    <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      hp_cnt   <= '0;
      edge_cnt <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          mosi_o <= 1'b1;
          sclk_o <= cpol_q;
          if (start_i) begin
            cpol_q   <= cpol_i;
            cpha_q   <= cpha_i;
            lsb_q    <= lsb_first_i;
            div_q    <= div_i;
            len_q    <= len_i;
            sclk_o   <= cpol_i;
            rx_sr    <= '0;
            hp_cnt   <= '0;
            edge_cnt <= '0;
            busy_o   <= 1'b1;
            state    <= SHIFT;
            // With cpha=0, the first bit must be valid before the first leading edge.
            if (cpha_i) begin
              mosi_o <= 1'b1;
              tx_sr  <= tx_load;
            end else begin
              mosi_o <= tx_load[0];
              tx_sr  <= tx_load >> 1;
            end
          end
        end
        SHIFT: begin
          if (hp_cnt == div_q) begin
            hp_cnt   <= '0;
            sclk_o   <= ~sclk_o;
            edge_cnt <= edge_cnt + 1'b1;
            // Each edge either samples or drives, never both. No bit is driven after the final edge.
            if (sample) begin
              rx_sr <= {rx_sr[DATA_W-2:0], miso_i};
            end else if (!last) begin
              mosi_o <= tx_sr[0];
              tx_sr  <= tx_sr >> 1;
            end
            if (last) state <= DONE;
          end else begin
            hp_cnt <= hp_cnt + 1'b1;
          end
        end
        DONE: begin
          done_o <= 1'b1;
          busy_o <= 1'b0;
          mosi_o <= 1'b1;
          // RX shifts in at bit 0, so the first received bit ends up at bit len.
          // That order is already correct for MSB-first and has to be mirrored for LSB-first.
          data_o <= lsb_q ? rev_len(rx_sr, len_q) : rx_sr;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_exch_word.sv
// Self-checking bench for spi_exch_word. The bench acts as the SPI slave.
// It shifts out its own word, captures MOSI at each sampling edge, and checks edge timing against k*(div+1).
module tb_spi_exch_word;

  logic        clk_i = 1'b0;
  logic        rst_i, start_i, cpol_i, cpha_i, lsb_first_i, miso_i;
  logic [7:0]  div_i;
  logic [3:0]  len_i;
  logic [15:0] data_i;
  logic        busy_o, done_o, sclk_o, mosi_o;
  logic [15:0] data_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  spi_exch_word #(.DATA_W(16), .DIV_W(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .cpol_i(cpol_i),
    .cpha_i(cpha_i), .lsb_first_i(lsb_first_i), .div_i(div_i), .len_i(len_i),
    .data_i(data_i), .miso_i(miso_i), .busy_o(busy_o), .done_o(done_o),
    .data_o(data_o), .sclk_o(sclk_o), .mosi_o(mosi_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns bit j of the wire order for word w: bit j for LSB-first, bit len-j for MSB-first.
  function automatic logic sbit(input logic [15:0] w, input logic lsb,
                                input logic [3:0] len, input logic [3:0] j);
    logic [3:0] idx;
    idx = lsb ? j : len - j;
    return w[idx];
  endfunction

  // One transfer. The call must start just after a negedge and returns at the negedge where done_o is seen.
  // With hold=1, start_i stays high and the config inputs are scrambled mid-transfer.
  task automatic run_xfer(input logic cpol, input logic cpha, input logic lsb,
                          input logic [7:0] div, input logic [3:0] len,
                          input logic [15:0] din, input logic [15:0] sw,
                          input bit hold, input string tag);
    int n, k, dcyc, limit;
    logic [15:0] srx, mask;
    logic [3:0]  j;
    bit tim_ok, busy_ok;
    logic sp, pm;
    n     = int'(len) + 1;
    mask  = 16'((32'h1 << n) - 1);
    limit = 2 * n * (int'(div) + 1) + 4;
    cpol_i = cpol; cpha_i = cpha; lsb_first_i = lsb;
    div_i = div; len_i = len; data_i = din;
    start_i = 1'b1;
    miso_i = cpha ? 1'b0 : sbit(sw, lsb, len, 4'd0);
    @(posedge clk_i);
    #1;
    if (!hold) start_i = 1'b0;
    @(negedge clk_i);
    chk({tag, "_busy_rise"}, 32'(busy_o), 32'd1);
    chk({tag, "_sclk_start"}, 32'(sclk_o), 32'(cpol));
    chk({tag, "_done_low"}, 32'(done_o), 32'd0);
    chk({tag, "_mosi_first"}, 32'(mosi_o), cpha ? 32'd1 : 32'(sbit(din, lsb, len, 4'd0)));
    sp = sclk_o; pm = mosi_o;
    k = 0; srx = '0; tim_ok = 1; busy_ok = 1; dcyc = -1;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk_i);
      if (hold && c == 3) begin
        cpol_i = ~cpol; cpha_i = ~cpha; lsb_first_i = ~lsb;
        div_i = 8'($urandom_range(0, 5)); len_i = 4'($urandom_range(0, 15));
        data_i = 16'($urandom);
      end
      if (sclk_o !== sp) begin
        k++;
        if (c != k * (int'(div) + 1)) tim_ok = 0;
        j = 4'((k - 1) / 2);
        if (((k % 2) == 1) != cpha) begin
          if (lsb) srx[j] = pm; else srx[len - j] = pm;
        end else if (cpha) begin
          miso_i = sbit(sw, lsb, len, j);
        end else if (k < 2 * n) begin
          miso_i = sbit(sw, lsb, len, 4'(k / 2));
        end
      end
      sp = sclk_o; pm = mosi_o;
      if (done_o === 1'b1) begin
        dcyc = c;
        break;
      end
      if (busy_o !== 1'b1) busy_ok = 0;
    end
    chk({tag, "_done_cycle"}, 32'(dcyc), 32'(2 * n * (int'(div) + 1) + 1));
    chk({tag, "_edges"}, 32'(k), 32'(2 * n));
    chk({tag, "_edge_timing"}, 32'(tim_ok), 32'd1);
    chk({tag, "_busy_during"}, 32'(busy_ok), 32'd1);
    chk({tag, "_busy_end"}, 32'(busy_o), 32'd0);
    chk({tag, "_sclk_end"}, 32'(sclk_o), 32'(cpol));
    chk({tag, "_mosi_end"}, 32'(mosi_o), 32'd1);
    chk({tag, "_data_o"}, 32'(data_o), 32'(sw & mask));
    chk({tag, "_slave_rx"}, 32'(srx), 32'(din & mask));
  endtask

  initial begin
    bit no_done;
    rst_i = 1'b1; start_i = 1'b0; cpol_i = 1'b0; cpha_i = 1'b0; lsb_first_i = 1'b0;
    div_i = '0; len_i = '0; data_i = '0; miso_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_data", 32'(data_o), 32'd0);
    chk("rst_sclk", 32'(sclk_o), 32'd0);
    chk("rst_mosi", 32'(mosi_o), 32'd1);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Directed modes
    run_xfer(1'b0, 1'b0, 1'b0, 8'd1, 4'd7, 16'h00A5, 16'h00A5, 1'b0, "mode0");
    @(negedge clk_i);
    run_xfer(1'b1, 1'b1, 1'b1, 8'd3, 4'd15, 16'h1234, 16'hBEEF, 1'b0, "mode3");
    @(negedge clk_i);
    run_xfer(1'b0, 1'b1, 1'b0, 8'd0, 4'd0, 16'h0001, 16'h0001, 1'b0, "mode1_len0");
    @(negedge clk_i);
    run_xfer(1'b1, 1'b0, 1'b0, 8'd0, 4'd0, 16'h0001, 16'h0001, 1'b0, "mode2_len0");
    @(negedge clk_i);

    // start_i held across three back-to-back transfers
    run_xfer(1'b0, 1'b0, 1'b0, 8'd2, 4'd5, 16'h002D, 16'h0013, 1'b1, "hold0");
    run_xfer(1'b1, 1'b1, 1'b1, 8'd0, 4'd9, 16'h0155, 16'h02AA, 1'b1, "hold1");
    run_xfer(1'b0, 1'b1, 1'b0, 8'd1, 4'd3, 16'hFFF9, 16'h0006, 1'b1, "hold2");
    start_i = 1'b0;
    @(negedge clk_i);

    // Reset while SCLK edge 5 is firing
    cpol_i = 1'b0; cpha_i = 1'b0; lsb_first_i = 1'b0; div_i = 8'd1; len_i = 4'd7;
    data_i = 16'h00C3; miso_i = 1'b1; start_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    repeat (10) @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("abort_busy", 32'(busy_o), 32'd0);
    chk("abort_sclk", 32'(sclk_o), 32'd0);
    chk("abort_mosi", 32'(mosi_o), 32'd1);
    chk("abort_data", 32'(data_o), 32'd0);
    no_done = 1;
    if (done_o !== 1'b0) no_done = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_i);
      if (done_o !== 1'b0 || busy_o !== 1'b0) no_done = 0;
    end
    chk("abort_no_done", 32'(no_done), 32'd1);
    run_xfer(1'b0, 1'b0, 1'b0, 8'd1, 4'd7, 16'h005A, 16'h0096, 1'b0, "after_abort");
    @(negedge clk_i);

    // Random regression
    for (int t = 0; t < 40; t++) begin
      run_xfer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               8'($urandom_range(0, 5)), 4'($urandom_range(0, 15)),
               16'($urandom), 16'($urandom), 1'b0, "rand");
      repeat (int'($urandom_range(1, 3))) @(negedge clk_i);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
